// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default
// link parameters, common to uart_rx and the future uart_tx.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 16;
  localparam int unsigned UART_DATA_WIDTH   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter for the UART receiver. Counts clk cycles since the last
// clear and raises a mid-bit strobe (count == CLKS_PER_BIT/2) and a
// full-bit strobe (count == CLKS_PER_BIT-1). Saturates instead of wrapping.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic mid_stb,
  output logic full_stb
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on request, otherwise count up and hold at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mid_stb  = (cnt_q == MID_CNT);
  assign full_stb = (cnt_q == FULL_CNT);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, start-bit glitch rejection, LSB-first
// data capture, stop-bit check, and a single holding register with a
// valid/ready handshake. Optional even parity enabled by UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  overrun
);

  localparam int unsigned BIT_W = 4;

  logic                  sync1_q, sync2_q;
  logic                  rx_s;
  uart_state_e           state_q, state_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  brk_wait_q, brk_wait_d;
  logic                  baud_clear, mid_stb, full_stb;
  logic                  deliver;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer for the asynchronous serial line (idle high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .mid_stb (mid_stb),
    .full_stb(full_stb)
  );

  // Frame FSM, shift register and holding-register handshake
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    brk_wait_d  = brk_wait_q;
    baud_clear  = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        baud_clear = 1'b1;
        bit_cnt_d  = '0;
        brk_wait_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = 1'b0;
`endif
        if (!rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (mid_stb) begin
          baud_clear = 1'b1;
          state_d    = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_stb) begin
          baud_clear = 1'b1;
          shift_d    = {rx_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (full_stb) begin
          baud_clear = 1'b1;
          state_d    = ST_STOP;
          if (rx_s != (^shift_q)) begin
            parity_err_d = 1'b1;
            par_bad_d    = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        // A low stop bit is held here until the line returns high so a
        // break condition cannot be mistaken for a new start bit.
        if (brk_wait_q) begin
          if (rx_s) begin
            brk_wait_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end else if (full_stb) begin
          baud_clear = 1'b1;
          if (rx_s) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            deliver = !par_bad_q;
`else
            deliver = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            brk_wait_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A completed byte is dropped only if the held one is not being taken
    if (deliver) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      brk_wait_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      brk_wait_q  <= brk_wait_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus a randomized burst,
// compared against a frame-level reference (expected byte queue and pulse
// counts derived from what was put on the line).
module tb_uart_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned DW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rxd;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  int            n_perr = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state (written only by the monitor process)
  logic [7:0] got_q[$];
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_long = 0;
  int run    = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  // Observe accepted bytes and pulse outputs on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_perr++;
`endif
      if (rx_valid) begin
        run++;
        if (run == 2) n_long++;
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic bit_out(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic bad_par);
    bit_out(1'b0);
    for (int i = 0; i < int'(DW); i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^b) ^ bad_par);
`endif
    bit_out(stop_v);
    rxd = 1'b1;
  endtask

  initial begin
    int         g0, f0, o0, l0, nbad;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       bad;
    int         gap;

    rxd      = 1'b1;
    rx_ready = 1'b1;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid",  rx_valid,  0);
    check("reset_rx_data",   rx_data,   0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun",   overrun,   0);
    reset = 1'b1;
    idle(10);

    // Single 0xA5 frame with consumer always ready
    g0 = got_q.size(); f0 = n_ferr; o0 = n_ovr; l0 = n_long;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("a5_count", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("a5_data", got_q[g0], 8'hA5);
    check("a5_one_cycle_valid", n_long - l0, 0);
    check("a5_no_frame_err", n_ferr - f0, 0);
    check("a5_no_overrun", n_ovr - o0, 0);
    check("a5_valid_cleared", rx_valid, 0);

    // Short low glitch must be rejected
    g0 = got_q.size(); f0 = n_ferr;
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(3 * CPB);
    check("glitch_no_valid", got_q.size() - g0, 0);
    check("glitch_no_frame_err", n_ferr - f0, 0);

    // Bad stop bit, then a good frame
    g0 = got_q.size(); f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(8);
    check("ferr_no_valid", got_q.size() - g0, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20);
    check("ferr_pulse_count", n_ferr - f0, 1);
    check("after_ferr_count", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("after_ferr_data", got_q[g0], 8'h55);

    // Back-to-back frames with consumer stalled -> overrun on the second
    o0 = n_ovr;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(20);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_pulse_count", n_ovr - o0, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("accept_clears_valid", rx_valid, 0);
    check("data_held_after_clear", rx_data, 8'h11);

    // Reset in the middle of 0xF0, then a fresh 0x0F
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_overrun", overrun, 0);
    rxd   = 1'b1;
    reset = 1'b1;
    idle(3 * CPB);
    g0 = got_q.size(); f0 = n_ferr;
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(20);
    check("postreset_count", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("postreset_data", got_q[g0], 8'h0F);
    check("postreset_no_frame_err", n_ferr - f0, 0);

    // Randomized burst: random bytes, random gaps, occasional bad stop bit
    g0 = got_q.size(); f0 = n_ferr; o0 = n_ovr; l0 = n_long; nbad = 0;
    for (int k = 0; k < 16; k++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, 1'b0);
      if (bad) nbad++;
      else exp_q.push_back(b);
      gap = bad ? int'($urandom_range(4, 40)) : int'($urandom_range(0, 40));
      if (gap > 0) idle(gap);
    end
    idle(20);
    check("rand_count", got_q.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g0 + i < got_q.size()) check($sformatf("rand_data_%0d", i), got_q[g0 + i], exp_q[i]);
    end
    check("rand_frame_err_count", n_ferr - f0, nbad);
    check("rand_no_overrun", n_ovr - o0, 0);
    check("rand_one_cycle_valid", n_long - l0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with a wrong (odd) parity bit is discarded
    begin
      int p0;
      g0 = got_q.size(); p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(20);
      check("parity_err_pulse", n_perr - p0, 1);
      check("parity_no_valid", got_q.size() - g0, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
